// File: rtl/dmem_access_ctrl_if.sv
// Request, memory and response signals between the MEM stage, the data
// memory and the dmem_access_ctrl sequencer.
interface dmem_access_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [5:0]        req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              busy;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  // Environment side: the pipeline drives requests and the memory returns read data.
  modport master (
    output req_valid, req_op, req_addr, req_wdata, mem_rdata,
    input  req_ready, busy, mem_en, mem_we, mem_addr, mem_wdata,
           rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, mem_rdata,
    output req_ready, busy, mem_en, mem_we, mem_addr, mem_wdata,
           rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_access_ctrl.sv
// Load/store sequencer for a single-port synchronous-read data memory,
// including read-modify-write for byte and halfword stores.
module dmem_access_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  dmem_access_ctrl_if.slave bus
);

  localparam logic [5:0] OP_LB  = 6'b001010;
  localparam logic [5:0] OP_LH  = 6'b001011;
  localparam logic [5:0] OP_LW  = 6'b001100;
  localparam logic [5:0] OP_LBU = 6'b001101;
  localparam logic [5:0] OP_LHU = 6'b001110;
  localparam logic [5:0] OP_SB  = 6'b001111;
  localparam logic [5:0] OP_SH  = 6'b010000;
  localparam logic [5:0] OP_SW  = 6'b010001;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    RDATA,
    MERGE,
    WR,
    ERR
  } state_e;

  state_e            state_q, state_d;
  logic [5:0]        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       merge_q, merge_d;

  logic              reqIsMem;
  logic              reqMisaligned;
  logic              capture;
  logic              opIsLoad;
  logic              opIsSw;
  logic [31:0]       mergedWord;
  logic [ADDR_W-1:0] alignedAddr;

  // Alignment is judged on the incoming request so the error path never touches memory.
  always_comb begin
    reqIsMem      = 1'b0;
    reqMisaligned = 1'b0;
    case (bus.req_op)
      OP_LB, OP_LBU, OP_SB: reqIsMem = 1'b1;
      OP_LH, OP_LHU, OP_SH: begin
        reqIsMem      = 1'b1;
        reqMisaligned = bus.req_addr[0];
      end
      OP_LW, OP_SW: begin
        reqIsMem      = 1'b1;
        reqMisaligned = |bus.req_addr[1:0];
      end
      default: ;
    endcase
  end

  assign capture     = bus.req_valid && (state_q == IDLE) && reqIsMem;
  assign opIsLoad    = (op_q == OP_LB) || (op_q == OP_LH) || (op_q == OP_LW) ||
                       (op_q == OP_LBU) || (op_q == OP_LHU);
  assign opIsSw      = (op_q == OP_SW);
  assign alignedAddr = {addr_q[ADDR_W-1:2], 2'b00};

  always_comb begin
    mergedWord = bus.mem_rdata;
    if (op_q == OP_SB) begin
      case (addr_q[1:0])
        2'd0:    mergedWord[7:0]   = wdata_q[7:0];
        2'd1:    mergedWord[15:8]  = wdata_q[7:0];
        2'd2:    mergedWord[23:16] = wdata_q[7:0];
        default: mergedWord[31:24] = wdata_q[7:0];
      endcase
    end else if (addr_q[1]) begin
      mergedWord[31:16] = wdata_q[15:0];
    end else begin
      mergedWord[15:0] = wdata_q[15:0];
    end
  end

  always_comb begin
    op_d    = capture ? bus.req_op    : op_q;
    addr_d  = capture ? bus.req_addr  : addr_q;
    wdata_d = capture ? bus.req_wdata : wdata_q;
    merge_d = (state_q == MERGE) ? mergedWord : merge_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      merge_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      merge_q <= merge_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (capture) begin
          if (reqMisaligned)           state_d = ERR;
          else if (bus.req_op == OP_SW) state_d = WR;
          else                         state_d = RD;
        end
      end
      RD:      state_d = opIsLoad ? RDATA : MERGE;
      MERGE:   state_d = WR;
      RDATA:   state_d = IDLE;
      WR:      state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Memory and response pins depend only on state and captured fields; read data
  // is forwarded raw in the response cycle.
  always_comb begin
    bus.req_ready = (state_q == IDLE);
    bus.busy      = (state_q != IDLE);
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.rsp_valid = 1'b0;
    bus.rsp_rdata = '0;
    bus.rsp_err   = 1'b0;
    case (state_q)
      RD: begin
        bus.mem_en   = 1'b1;
        bus.mem_addr = alignedAddr;
      end
      RDATA: begin
        bus.rsp_valid = 1'b1;
        bus.rsp_rdata = bus.mem_rdata;
      end
      WR: begin
        bus.mem_en    = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = alignedAddr;
        bus.mem_wdata = opIsSw ? wdata_q : merge_q;
        bus.rsp_valid = 1'b1;
      end
      ERR: begin
        bus.rsp_valid = 1'b1;
        bus.rsp_err   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
